// File: rtl/fp_add_pipe_if.sv
// Operand/result handshake bundle for fp_add_pipe.
// master drives operands and out_ready; slave is the adder.
interface fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_ovf;
  logic         out_inv;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_res, out_ovf, out_inv
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_res, out_ovf, out_inv
  );
endinterface

// File: rtl/fp_add_pipe.sv
// Parametrised FP add/sub, round-to-nearest-even: align -> add -> normalise/round, 3-cycle latency.
// One op/cycle; a single advance enable freezes every stage (valids included) while the output is stalled.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          rst,
  fp_add_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 4;
  localparam int LZ_W = $clog2(MW + 1);
  localparam int XW   = EXP_W + LZ_W + 2;
  localparam logic [EXP_W-1:0]       EXP_ONES = '1;
  localparam logic signed [XW-1:0]   EXP_MAX  = {{(XW-EXP_W){1'b0}}, EXP_ONES};
  localparam logic [W-1:0]           QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_res;
    logic             spec_inv;
    logic             sign;
    logic [EXP_W-1:0] exp;
  } meta_t;

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- stage 1: unpack, specials, swap, align ----------------
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;
  assign {a_s, a_e, a_f} = bus.in_a;
  assign b_s = bus.in_b[W-1] ^ bus.in_sub;
  assign b_e = bus.in_b[W-2 -: EXP_W];
  assign b_f = bus.in_b[MAN_W-1:0];

  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [EXP_W-1:0] diff;
  logic [MW-1:0]    sm_raw, sm_sh, big_d, small_d;
  meta_t            s1_d;

  always_comb begin
    a_zero  = (a_e == '0);
    b_zero  = (b_e == '0);
    a_inf   = (a_e == EXP_ONES) && (a_f == '0);
    b_inf   = (b_e == EXP_ONES) && (b_f == '0);
    a_nan   = (a_e == EXP_ONES) && (a_f != '0);
    b_nan   = (b_e == EXP_ONES) && (b_f != '0);
    a_big   = {a_e, a_f} >= {b_e, b_f};
    diff    = a_big ? (a_e - b_e) : (b_e - a_e);
    big_d   = {1'b1, (a_big ? a_f : b_f), 3'b000};
    sm_raw  = {1'b1, (a_big ? b_f : a_f), 3'b000};
    sm_sh   = sm_raw >> diff;
    // everything shifted past the sticky position collapses into it
    small_d = {sm_sh[MW-1:1], sm_sh[0] | (|(sm_raw & ~({MW{1'b1}} << diff)))};

    s1_d      = '0;
    s1_d.sign = a_big ? a_s : b_s;
    s1_d.exp  = a_big ? a_e : b_e;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = QNAN;
      s1_d.spec_inv = 1'b1;
    end else if (a_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {a_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {b_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {a_s & b_s, {(W-1){1'b0}}};
    end else if (a_zero) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {b_s, b_e, b_f};
    end else if (b_zero) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {a_s, a_e, a_f};
    end
  end

  logic          s1_vld, s1_sub;
  meta_t         s1_meta;
  logic [MW-1:0] s1_big, s1_small;

  // ---------------- stage 2: magnitude add/subtract ----------------
  logic [MW:0] sum_d;
  assign sum_d = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                        : ({1'b0, s1_big} + {1'b0, s1_small});

  logic        s2_vld;
  meta_t       s2_meta;
  logic [MW:0] s2_sum;

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [LZ_W-1:0]       lzc;
  logic [MW-1:0]         m_n;
  logic [MAN_W:0]        m_r;
  logic signed [XW-1:0]  e_n, e_r;
  logic                  rnd_up;
  logic [W-1:0]          res_d;
  logic                  ovf_d, inv_d;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < MW; i++) begin
      if (s2_sum[i]) lzc = LZ_W'(MW - 1 - i);
    end
    if (s2_sum[MW]) begin
      m_n = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
      e_n = XW'(s2_meta.exp) + XW'(1);
    end else begin
      m_n = s2_sum[MW-1:0] << lzc;
      e_n = XW'(s2_meta.exp) - XW'(lzc);
    end
    // hidden bit is 1 after normalising, so a fraction carry-out means 10.000.. -> exp+1, frac 0
    rnd_up = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
    m_r    = {1'b0, m_n[MW-2:3]} + (MAN_W+1)'(rnd_up);
    e_r    = e_n + XW'(m_r[MAN_W]);

    res_d = '0;
    ovf_d = 1'b0;
    inv_d = 1'b0;
    if (s2_meta.spec) begin
      res_d = s2_meta.spec_res;
      inv_d = s2_meta.spec_inv;
    end else if (!m_n[MW-1]) begin
      res_d = '0;
    end else if (e_n <= 0) begin
      res_d = {s2_meta.sign, {(W-1){1'b0}}};
    end else if (e_r >= EXP_MAX) begin
      res_d = {s2_meta.sign, EXP_ONES, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      res_d = {s2_meta.sign, e_r[EXP_W-1:0], m_r[MAN_W-1:0]};
    end
  end

  logic         out_vld_q, ovf_q, inv_q;
  logic [W-1:0] res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_sub    <= 1'b0;
      s1_meta   <= '0;
      s1_big    <= '0;
      s1_small  <= '0;
      s2_vld    <= 1'b0;
      s2_meta   <= '0;
      s2_sum    <= '0;
      out_vld_q <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else if (adv) begin
      s1_vld    <= bus.in_valid;
      s1_sub    <= a_s ^ b_s;
      s1_meta   <= s1_d;
      s1_big    <= big_d;
      s1_small  <= small_d;
      s2_vld    <= s1_vld;
      s2_meta   <= s1_meta;
      s2_sum    <= sum_d;
      out_vld_q <= s2_vld;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      inv_q     <= inv_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_res   = res_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_inv   = inv_q;
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed-vector bench for fp_add_pipe: single and half precision instances,
// back-pressure stream and mid-stream reset.
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) sp ();
  fp_add_pipe_if #(.EXP_W(5), .MAN_W(10)) hp ();

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .rst(rst), .bus(sp.slave));
  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst(rst), .bus(hp.slave));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sub;
    bit          half;
    logic [31:0] res;
    bit          ovf;
    bit          inv;
  } vec_t;

  vec_t        vecs [19];
  logic [31:0] flt [8];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] r, held;
  logic        o, v;
  int          lat, k, n;
  bit          stall, prev_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // present one op, wait (bounded) for its result; lat counts edges from acceptance
  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b, input bit sub,
                        output logic [31:0] res, output logic ovf, output logic inv, output int lt);
    res = 'x; ovf = 1'bx; inv = 1'bx; lt = -1;
    if (half) begin
      hp.in_valid = 1'b1; hp.in_a = a[15:0]; hp.in_b = b[15:0]; hp.in_sub = sub;
    end else begin
      sp.in_valid = 1'b1; sp.in_a = a; sp.in_b = b; sp.in_sub = sub;
    end
    #1;
    check("op_in_ready", 32'(half ? hp.in_ready : sp.in_ready), 32'd1);
    @(posedge clk); #1;
    hp.in_valid = 1'b0;
    sp.in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if ((half ? hp.out_valid : sp.out_valid) === 1'b1) begin
        lt  = c;
        res = half ? {16'h0, hp.out_res} : sp.out_res;
        ovf = half ? hp.out_ovf : sp.out_ovf;
        inv = half ? hp.out_inv : sp.out_inv;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                a             b             sub   half  res           ovf   inv
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0};
    vecs[3]  = '{32'hC0400000, 32'h3F800000, 1'b0, 1'b0, 32'hC0000000, 1'b0, 1'b0};
    vecs[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[5]  = '{32'h3F800000, 32'h33800001, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0};
    vecs[6]  = '{32'h3F800000, 32'h25800000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    vecs[8]  = '{32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
    vecs[10] = '{32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 32'h7F800000, 1'b0, 1'b0};
    vecs[11] = '{32'h00000000, 32'h40490FDB, 1'b0, 1'b0, 32'h40490FDB, 1'b0, 1'b0};
    vecs[12] = '{32'h40000000, 32'h3F800000, 1'b1, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[13] = '{32'h00000001, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[14] = '{32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[15] = '{32'h80000000, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0};
    vecs[16] = '{32'h3F7FFFFF, 32'h33000000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[17] = '{32'h00003C00, 32'h00003C00, 1'b0, 1'b1, 32'h00004000, 1'b0, 1'b0};
    vecs[18] = '{32'h00007BFF, 32'h00007BFF, 1'b0, 1'b1, 32'h00007C00, 1'b1, 1'b0};
    flt[0] = 32'h3F800000; flt[1] = 32'h40000000; flt[2] = 32'h40400000; flt[3] = 32'h40800000;
    flt[4] = 32'h40A00000; flt[5] = 32'h40C00000; flt[6] = 32'h40E00000; flt[7] = 32'h41000000;

    rst = 1'b0;
    sp.in_valid = 1'b0; sp.in_a = '0; sp.in_b = '0; sp.in_sub = 1'b0; sp.out_ready = 1'b1;
    hp.in_valid = 1'b0; hp.in_a = '0; hp.in_b = '0; hp.in_sub = 1'b0; hp.out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sp_out_valid", 32'(sp.out_valid), 32'd0);
    check("rst_sp_out_res",   sp.out_res, 32'd0);
    check("rst_sp_out_ovf",   32'(sp.out_ovf), 32'd0);
    check("rst_sp_out_inv",   32'(sp.out_inv), 32'd0);
    check("rst_sp_in_ready",  32'(sp.in_ready), 32'd1);
    check("rst_hp_out_valid", 32'(hp.out_valid), 32'd0);
    check("rst_hp_in_ready",  32'(hp.in_ready), 32'd1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].half, vecs[i].a, vecs[i].b, vecs[i].sub, r, o, v, lat);
      check($sformatf("vec%0d_res", i), r, vecs[i].res);
      check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_inv", i), 32'(v), 32'(vecs[i].inv));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
    end
    repeat (4) @(posedge clk);
    #1;

    // six back-to-back ops, output stalled in cycles 4..7
    k = 0; n = 0; prev_stall = 1'b0; held = '0;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      sp.out_ready = !(c >= 4 && c <= 7);
      if (k < 6) begin
        sp.in_valid = 1'b1; sp.in_a = flt[k+1]; sp.in_b = flt[0]; sp.in_sub = 1'b0;
      end else begin
        sp.in_valid = 1'b0;
      end
      #1;
      stall = sp.out_valid && !sp.out_ready;
      if (stall) check($sformatf("bp_in_ready_c%0d", c), 32'(sp.in_ready), 32'd0);
      if (stall && prev_stall) check($sformatf("bp_stable_c%0d", c), sp.out_res, held);
      if (sp.out_valid && sp.out_ready) begin
        check($sformatf("bp_res%0d", n), sp.out_res, flt[n+2]);
        n++;
      end
      if (sp.in_valid && sp.in_ready) k++;
      prev_stall = stall;
      held = sp.out_res;
      @(posedge clk); #1;
    end
    sp.in_valid  = 1'b0;
    sp.out_ready = 1'b1;
    check("bp_out_count", 32'(n), 32'd6);
    check("bp_in_count",  32'(k), 32'd6);
    repeat (3) begin
      check("bp_no_extra", 32'(sp.out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // three ops in flight, then asynchronous reset
    for (int c = 0; c < 3; c++) begin
      sp.in_valid = 1'b1; sp.in_a = flt[c]; sp.in_b = flt[0]; sp.in_sub = 1'b0;
      @(posedge clk); #1;
    end
    sp.in_valid = 1'b0;
    check("mid_pre_out_valid", 32'(sp.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(sp.out_valid), 32'd0);
    check("mid_rst_out_res",   sp.out_res, 32'd0);
    check("mid_rst_in_ready",  32'(sp.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("mid_post_out_valid_c%0d", c), 32'(sp.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_op(1'b0, 32'h40000000, 32'h40000000, 1'b0, r, o, v, lat);
    check("mid_next_res", r, 32'h40800000);
    check("mid_next_lat", 32'(lat), 32'd3);
    check("mid_next_ovf", 32'(o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, pipelined floating-point adder/subtractor with IEEE-754-style packing, round-to-nearest-even and valid/ready flow control. Successor to the team's combinational single-precision adder: exponent and mantissa widths are parameters, a per-operation subtract mode is added, and the datapath is split into three registered stages. It sits between operand sources and the accumulator/normaliser logic, accepting one operation per cycle when not back-pressured.

## Interface

- `EXP_W`, default 8: exponent field width (≥3).
- `MAN_W`, default 23: stored fraction width; the hidden bit is implicit.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  operation accepted when `in_valid && in_ready`.
- `in_a`, `in_b`  in  1+EXP_W+MAN_W each  packed {sign, exp, frac}.
- `in_sub`  in  1  1: compute a−b (b sign inverted); 0: a+b.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `out_res`  out  1+EXP_W+MAN_W  packed result.
- `out_ovf`  out  1  result overflowed to ±infinity.
- `out_inv`  out  1  invalid operation (NaN input or ∞−∞).

## Operation

- Stage 1 (align):
  - Unpack. exp=0 means zero; denormals are flushed to zero, and their fraction is ignored. exp=all-ones means inf (frac=0) or NaN (frac≠0).
  - Apply `in_sub` to the b sign.
  - Swap so that the operand with the larger {exp,frac} magnitude is the big operand.
  - Right-shift the small mantissa {1,frac} by the exponent difference into MAN_W+4 bits (hidden, frac, guard, round, sticky). All shifted-out bits OR into sticky. A difference ≥ MAN_W+3 leaves only sticky.
- Stage 2 (add):
  - Equal signs: add magnitudes, with a carry bit.
  - Different signs: subtract small from big; the result is non-negative.
  - Result sign is the big operand's sign.
  - Exponent carried is the big exponent.
- Stage 3 (normalise/round/pack):
  - On carry: shift right 1 (sticky accumulates) and exponent+1.
  - Otherwise: leading-zero count, left shift, exponent−LZC. Exponent underflow (≤0) flushes to signed zero.
  - Round to nearest even on the guard/round/sticky bits. A mantissa carry-out from rounding increments the exponent.
  - Exponent ≥ all-ones gives ±inf with `out_ovf`=1.
- Special cases, resolved in stage 1 and carried as a flag:
  - Any NaN input, or inf + (−inf) after `in_sub` is applied, gives canonical NaN {0, all-ones, 1 followed by zeros} with `out_inv`=1.
  - inf with a finite operand gives that inf, with flags 0.
  - Exact cancellation (magnitude 0) gives +0, except (−0)+(−0), which gives −0.
  - A zero operand gives the other operand, exact.
- `out_ovf` and `out_inv` are valid only with `out_valid`. Both are 0 in all other cases.

## Timing

- Latency: 3 cycles from acceptance to `out_valid`, with no stalls.
- Throughput: 1 operation per cycle.
- Flow control:
  - Global advance enable `adv = !out_valid || out_ready`.
  - `in_ready = adv`, combinational, with no dependence on `in_valid`.
  - When `adv`=0, all stage registers, including the valid bits, hold.
  - Bubbles advance like data and are not collapsed.
- Outputs:
  - `out_res`, `out_ovf` and `out_inv` are stable while `out_valid && !out_ready`.
  - Outputs are registered directly from stage 3; there is no combinational input-to-output path.
- Reset:
  - Asserting `rst` clears all stage valid bits immediately. In-flight operations are discarded, never emitted.
  - Reset values: `out_valid`=0, `out_res`=0, `out_ovf`=0, `out_inv`=0. `in_ready`=1 while in reset and after it.
  - The first acceptance is possible on the first rising edge after deassertion.
- Stall and accept in the same cycle: if `out_ready`=1 while `out_valid`=1 and `in_valid`=1, the output is consumed and the input accepted on that edge.

## Test plan

- 0x3F800000 + 0x40000000 (`in_sub`=0) -> 0x40400000 at cycle 3, flags 0.
- Subtraction and zero handling:
  - 0x3F800000 − 0x3F800000 (`in_sub`=1) -> 0x00000000.
  - 0x80000000 + 0x80000000 -> 0x80000000.
  - 0xC0400000 + 0x3F800000 -> 0xC0000000.
- Rounding:
  - 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even).
  - 0x3F800000 + 0x33800001 -> 0x3F800001.
  - 0x3F800000 + 0x25800000 -> 0x3F800000 (sticky only).
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, `out_ovf`=1.
  - 0x7F800000 − 0x7F800000 -> 0x7FC00000, `out_inv`=1.
  - 0x7FC00000 + 0x3F800000 -> 0x7FC00000, `out_inv`=1.
- Back-pressure:
  - Stream 6 back-to-back operations while holding `out_ready`=0 for cycles 4–7.
  - Required: exactly 6 results, in order, none duplicated or lost. `in_ready`=0 during the stall. `out_res` is stable while stalled.
- Reset mid-stream:
  - Assert `rst` with 3 operations in flight.
  - Required: `out_valid`=0 immediately and for the 3 following cycles after release. The next accepted 0x40000000 + 0x40000000 returns 0x40800000.
- Parameters: `EXP_W`=5, `MAN_W`=10 (half precision), 0x3C00 + 0x3C00 -> 0x4000 and 0x7BFF + 0x7BFF -> 0x7C00 with `out_ovf`=1.
